// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes from load-use, Execute redirects and
// data-memory waits, with saturating stall/flush counters and a sticky memory timeout error.
module pipeline_hazard_ctrl #(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH              = 16,
    parameter int MEM_TIMEOUT            = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              resultSrcE_i,
    input  logic                              regWriteE_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs1D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs2D_i,
    input  logic                              useRs1D_i,
    input  logic                              useRs2D_i,
    input  logic                              redirectE_i,
    input  logic                              memReqM_i,
    input  logic                              memReadyM_i,
    output logic                              enPC_o,
    output logic                              enD_o,
    output logic                              enE_o,
    output logic                              enM_o,
    output logic                              enW_o,
    output logic                              flushD_o,
    output logic                              flushE_o,
    output logic [CNT_WIDTH-1:0]              stallCnt_o,
    output logic [CNT_WIDTH-1:0]              flushCnt_o,
    output logic                              memErr_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]    WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t                state_reg, state_next;
    logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [CNT_WIDTH-1:0]  stall_cnt_reg, flush_cnt_reg;
    logic                  mem_err_reg, mem_err_next;
    logic                  flush_inc;

    logic [REGISTER_ADDRESS_WIDTH-1:0] src_reg_d [2];
    logic [1:0]                        src_used;
    logic [1:0]                        src_match;
    logic                              load_use;
    logic                              mem_stall;

    assign src_reg_d[0] = rs1D_i;
    assign src_reg_d[1] = rs2D_i;
    assign src_used     = {useRs2D_i, useRs1D_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
            assign src_match[gi] = src_used[gi] & (src_reg_d[gi] == AD3E_i);
        end
    endgenerate

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use  = resultSrcE_i & regWriteE_i & (AD3E_i != '0) & (|src_match);
    assign mem_stall = memReqM_i & ~memReadyM_i;

    always_comb begin
        enPC_o        = 1'b0;
        enD_o         = 1'b0;
        enE_o         = 1'b0;
        enM_o         = 1'b0;
        enW_o         = 1'b0;
        flushD_o      = 1'b0;
        flushE_o      = 1'b0;
        flush_inc     = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;

        if (rst) begin
            flushD_o = 1'b1;
            flushE_o = 1'b1;
        end else begin
            unique case (state_reg)
                ST_RUN: begin
                    if (mem_stall) begin
                        state_next    = ST_MEM_WAIT;
                        wait_cnt_next = WAIT_ONE;
                    end else if (redirectE_i) begin
                        // Decode instruction is squashed, so any load-use on it is moot.
                        {enPC_o, enD_o, enE_o, enM_o, enW_o} = '1;
                        flushD_o  = 1'b1;
                        flushE_o  = 1'b1;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        enE_o    = 1'b1;
                        enM_o    = 1'b1;
                        enW_o    = 1'b1;
                        flushE_o = 1'b1;
                    end else begin
                        {enPC_o, enD_o, enE_o, enM_o, enW_o} = '1;
                    end
                end
                ST_MEM_WAIT: begin
                    // Completing cycle stays frozen; held inputs are acted on next RUN cycle.
                    if (memReadyM_i) begin
                        state_next    = ST_RUN;
                        wait_cnt_next = '0;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_next    = ST_ERROR;
                        wait_cnt_next = '0;
                        mem_err_next  = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_ONE;
                    end
                end
                ST_ERROR: begin
                    state_next = ST_ERROR;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
            mem_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
            if (!enPC_o && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            end
            if (flush_inc && flush_cnt_reg != '1) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
            end
        end
    end

    assign stallCnt_o = stall_cnt_reg;
    assign flushCnt_o = flush_cnt_reg;
    assign memErr_o   = mem_err_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle-level behavioural model,
// preceded by directed scenarios for reset, load-use, redirect, memory wait, timeout and saturation.
module tb_pipeline_hazard_ctrl;

    localparam int RAW = 5;
    localparam int CW  = 4;
    localparam int TO  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           resultSrcE, regWriteE, useRs1D, useRs2D, redirectE, memReqM, memReadyM;
    logic [RAW-1:0] AD3E, rs1D, rs2D;
    logic           enPC, enD, enE, enM, enW, flushD, flushE, memErr;
    logic [CW-1:0]  stallCnt, flushCnt;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Behavioural model: elapsed wait cycles (0 = not waiting), sticky error, counters.
    int m_waits = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl #(
        .REGISTER_ADDRESS_WIDTH(RAW),
        .CNT_WIDTH(CW),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .resultSrcE_i(resultSrcE),
        .regWriteE_i(regWriteE),
        .AD3E_i(AD3E),
        .rs1D_i(rs1D),
        .rs2D_i(rs2D),
        .useRs1D_i(useRs1D),
        .useRs2D_i(useRs2D),
        .redirectE_i(redirectE),
        .memReqM_i(memReqM),
        .memReadyM_i(memReadyM),
        .enPC_o(enPC),
        .enD_o(enD),
        .enE_o(enE),
        .enM_o(enM),
        .enW_o(enW),
        .flushD_o(flushD),
        .flushE_o(flushE),
        .stallCnt_o(stallCnt),
        .flushCnt_o(flushCnt),
        .memErr_o(memErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic idle();
        rst        = 1'b0;
        resultSrcE = 1'b0;
        regWriteE  = 1'b0;
        AD3E       = '0;
        rs1D       = '0;
        rs2D       = '0;
        useRs1D    = 1'b0;
        useRs2D    = 1'b0;
        redirectE  = 1'b0;
        memReqM    = 1'b0;
        memReadyM  = 1'b0;
    endtask

    // One clock cycle: inputs already applied; check against the model, then advance it.
    task automatic cycle();
        logic [6:0] exp_ctrl;
        bit         lu, ms, redir_taken;
        #1;
        lu = resultSrcE && regWriteE && (AD3E != 0) &&
             ((useRs1D && rs1D == AD3E) || (useRs2D && rs2D == AD3E));
        ms = memReqM && !memReadyM;
        redir_taken = 1'b0;
        // Order: enPC enD enE enM enW flushD flushE
        if (rst)                            exp_ctrl = 7'b0000011;
        else if (m_err || m_waits > 0 || ms) exp_ctrl = 7'b0000000;
        else if (redirectE) begin
            exp_ctrl    = 7'b1111111;
            redir_taken = 1'b1;
        end
        else if (lu)                        exp_ctrl = 7'b0011101;
        else                                exp_ctrl = 7'b1111100;

        check("ctrl", {25'd0, enPC, enD, enE, enM, enW, flushD, flushE}, {25'd0, exp_ctrl});
        check("stall_cnt", {28'd0, stallCnt}, m_stall);
        check("flush_cnt", {28'd0, flushCnt}, m_flush);
        check("mem_err", {31'd0, memErr}, {31'd0, m_err});
        $display("cyc %0d rst=%b lu=%b redir=%b req=%b rdy=%b ctrl=%b stall=%0d flush=%0d err=%b",
                 cyc, rst, lu, redirectE, memReqM, memReadyM,
                 {enPC, enD, enE, enM, enW, flushD, flushE}, stallCnt, flushCnt, memErr);

        @(posedge clk);
        if (rst) begin
            m_waits = 0;
            m_err   = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!exp_ctrl[6] && m_stall < SAT) m_stall++;
            if (redir_taken && m_flush < SAT)  m_flush++;
            if (m_err) begin
                // stays in error until reset
            end else if (m_waits > 0) begin
                if (memReadyM) m_waits = 0;
                else begin
                    m_waits++;
                    if (m_waits == TO) begin
                        m_err   = 1'b1;
                        m_waits = 0;
                    end
                end
            end else if (ms) begin
                m_waits = 1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        idle();
        rst = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b0;
    endtask

    initial begin
        idle();

        // Reset held two cycles, then a quiet cycle.
        do_reset(2);
        check("post_reset_stall", {28'd0, stallCnt}, 32'd0);
        check("post_reset_flush", {28'd0, flushCnt}, 32'd0);
        cycle();

        // Load-use on rs2, then the same with destination x0.
        resultSrcE = 1'b1; regWriteE = 1'b1; AD3E = 5'd5; rs2D = 5'd5; useRs2D = 1'b1;
        cycle();
        check("lu_stall_cnt", {28'd0, stallCnt}, 32'd1);
        AD3E = 5'd0; rs2D = 5'd0;
        cycle();
        check("lu_x0_stall_cnt", {28'd0, stallCnt}, 32'd1);
        idle();

        // Redirect together with load-use.
        do_reset(1);
        resultSrcE = 1'b1; regWriteE = 1'b1; AD3E = 5'd7; rs1D = 5'd7; useRs1D = 1'b1; redirectE = 1'b1;
        cycle();
        check("redir_flush_cnt", {28'd0, flushCnt}, 32'd1);
        check("redir_stall_cnt", {28'd0, stallCnt}, 32'd0);
        idle();

        // Memory wait: three not-ready cycles then completion.
        do_reset(1);
        memReqM = 1'b1; memReadyM = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        memReadyM = 1'b1;
        cycle();
        check("memwait_stall_cnt", {28'd0, stallCnt}, 32'd4);
        idle();
        cycle();

        // Timeout: ready never rises.
        do_reset(1);
        memReqM = 1'b1; memReadyM = 1'b0;
        for (int i = 0; i < TO; i++) cycle();
        check("timeout_err", {31'd0, memErr}, 32'd1);
        for (int i = 0; i < 2; i++) cycle();
        do_reset(1);
        check("err_cleared", {31'd0, memErr}, 32'd0);
        idle();
        cycle();

        // Stall counter saturation.
        resultSrcE = 1'b1; regWriteE = 1'b1; AD3E = 5'd3; rs1D = 5'd3; useRs1D = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("stall_saturated", {28'd0, stallCnt}, SAT);
        idle();
        do_reset(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit frozen;
            frozen = (m_waits > 0) || m_err;
            rst = ($urandom_range(0, 99) < (m_err ? 15 : 1));
            if (frozen) begin
                memReadyM = ($urandom_range(0, 99) < 40);
            end else begin
                resultSrcE = $urandom_range(0, 1);
                regWriteE  = ($urandom_range(0, 99) < 80);
                AD3E       = RAW'($urandom_range(0, 3));
                rs1D       = RAW'($urandom_range(0, 3));
                rs2D       = RAW'($urandom_range(0, 3));
                useRs1D    = $urandom_range(0, 1);
                useRs2D    = $urandom_range(0, 1);
                redirectE  = ($urandom_range(0, 99) < 15);
                memReqM    = ($urandom_range(0, 99) < 25);
                memReadyM  = ($urandom_range(0, 99) < 50);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the four pipeline registers (F/D, D/E, E/M, M/W) and the PC.
- Generates per-stage enables and flushes from load-use hazards, taken control transfers resolved in Execute, and data-memory wait handshakes.
- Keeps saturating stall/flush performance counters.
- Latches a sticky error if the data memory fails to answer within a timeout.

Parameters:
REGISTER_ADDRESS_WIDTH, 5, width of register specifiers
CNT_WIDTH, 16, width of the stall and flush performance counters
MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before error (>=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
resultSrcE_i  in  1  instruction in Execute is a load
regWriteE_i  in  1  instruction in Execute writes a register
AD3E_i  in  REGISTER_ADDRESS_WIDTH  destination register in Execute
rs1D_i  in  REGISTER_ADDRESS_WIDTH  source register 1 in Decode
rs2D_i  in  REGISTER_ADDRESS_WIDTH  source register 2 in Decode
useRs1D_i  in  1  Decode instruction reads rs1
useRs2D_i  in  1  Decode instruction reads rs2
redirectE_i  in  1  taken branch, JAL or JALR resolved in Execute
memReqM_i  in  1  Memory stage issues a data-memory access
memReadyM_i  in  1  data memory completes the access this cycle
enPC_o  out  1  PC register enable
enD_o  out  1  F/D register enable
enE_o  out  1  D/E register enable
enM_o  out  1  E/M register enable
enW_o  out  1  M/W register enable
flushD_o  out  1  load NOP into F/D
flushE_o  out  1  load NOP into D/E
stallCnt_o  out  CNT_WIDTH  cycles with enPC_o=0, saturating
flushCnt_o  out  CNT_WIDTH  redirect flushes taken, saturating
memErr_o  out  1  sticky timeout error

Behaviour:
Clock and reset:
- Single clock `clk`; `rst` is synchronous and active-high.
- While `rst`=1: all en*=0, flushD_o=flushE_o=1.
- Next cycle after reset: state=RUN, stallCnt_o=0, flushCnt_o=0, memErr_o=0, wait counter=0.

States: RUN, MEM_WAIT, ERROR. All outputs are combinational from state and inputs; the only registers are state and counters.

Hazard terms:
- loadUse = resultSrcE_i & regWriteE_i & (AD3E_i!=0) & ((useRs1D_i & rs1D_i==AD3E_i) | (useRs2D_i & rs2D_i==AD3E_i)).
- memStall = memReqM_i & ~memReadyM_i.

Priority in RUN, highest first:
1. memStall: all en*=0, flushes=0; go to MEM_WAIT; wait counter=1.
2. redirectE_i: all en*=1, flushD_o=1, flushE_o=1; flushCnt_o+1. loadUse is ignored because the Decode instruction is squashed.
3. loadUse: enPC_o=0, enD_o=0, enE_o=1, flushE_o=1 (bubble), enM_o=enW_o=1. Lasts exactly 1 cycle, since the load advances to M next cycle.
4. Otherwise: all en*=1, flushes=0.

MEM_WAIT:
- All en*=0, flushes=0. Redirect and loadUse are not acted on; inputs stay stable because the pipeline is frozen.
- memReadyM_i=1: go to RUN and evaluate priorities 2-4 with the held inputs in that RUN cycle. The completing cycle itself keeps en*=0, so M/W captures on the following RUN cycle.
- Otherwise: wait counter+1. When the counter reaches MEM_TIMEOUT, go to ERROR and set memErr_o=1.

ERROR:
- All en*=0, flushes=0. Held until `rst`; memErr_o stays 1.

Counters:
- stallCnt_o increments on every non-reset cycle with enPC_o=0 (loadUse, MEM_WAIT, ERROR).
- Both counters saturate at all-ones and never wrap.

Simultaneous events:
- memStall together with redirect or loadUse: memStall wins; the other event is handled after release.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN with counters cleared.

Test Plan:
1. Reset held 2 cycles, then released with no hazards → during reset en*=0, flushD_o=flushE_o=1; afterwards en*=1, flushes=0, counters 0.
2. Load-use: resultSrcE_i=1, regWriteE_i=1, AD3E_i=5, rs2D_i=5, useRs2D_i=1 for one cycle → enPC_o=enD_o=0, flushE_o=1, enE_o=1, stallCnt_o=1. Repeat with AD3E_i=0 → no stall.
3. Redirect and loadUse in the same cycle → flushD_o=flushE_o=1, enPC_o=1, flushCnt_o=1, stallCnt_o unchanged.
4. memReqM_i=1 with memReadyM_i low for 3 cycles, then high → en*=0 for 4 cycles (3 wait + completion), stallCnt_o=4, back to RUN with en*=1.
5. MEM_TIMEOUT=4, memReadyM_i never rises → ERROR after 4 wait cycles, memErr_o=1 and en*=0 held. rst then clears memErr_o and state returns to RUN.
6. CNT_WIDTH=4, 20 consecutive load-use cycles → stallCnt_o saturates at 15.
